final385_soc_switch_ctrl: RTL
=============================

# final385_soc_switch_ctrl

Avalon-MM slave controller for the board slide switches / push buttons, replacing the plain input PIO in the final385_soc Qsys system. It synchronizes and debounces each input bit with a software-programmable period, captures rising edges into a sticky register, and raises a maskable interrupt to the Nios II. Software reads clean switch state and services button presses by interrupt instead of polling raw pins.

## Interface
- WIDTH, 4: number of input bits.
- DB_W, 16: debounce counter / period register width.
- DB_RESET, 50000: reset value of the debounce period (1 ms at 50 MHz).

- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous and active-low; one clock domain only.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered.
- in_port  in  WIDTH  raw asynchronous pins.
- irq  out  1  interrupt, level, active-high.

## Operation
- Register map (word address): 0 DATA (RO, debounced state, zero-extended); 1 PERIOD (RW, low DB_W bits); 2 IRQMASK (RW, low WIDTH bits); 3 EDGECAP (read; write-1-to-clear per bit).
- Write occurs when chipselect=1 and write_n=0; writes to DATA ignored; upper writedata bits ignored.
- readdata <= read mux of address every clock (chipselect not qualified), read latency 1; unused bits 0.
- Per bit i: 2-FF synchronizer sync1→sync2; stable[i] register; counter cnt[i] (DB_W bits).
  - sync2==stable: cnt<=0.
  - sync2!=stable and cnt==N-1: stable<=sync2, cnt<=0; N = max(PERIOD,1).
  - otherwise cnt<=cnt+1.
- Edge capture: EDGECAP[i] set on the edge where stable[i] changes 0→1. Falling transitions never set it.
- Set and write-1-clear on the same edge: set wins (bit stays 1).
- irq = |(EDGECAP & IRQMASK), combinational from registers, no glitch source.
- PERIOD write takes effect next cycle; in-flight counters keep counting and compare against the new N; a counter already ≥ N-1 completes on the next mismatched cycle.
- Reset values: readdata 0, irq 0, sync1/sync2/stable 0, cnt 0, EDGECAP 0, IRQMASK 0, PERIOD DB_RESET. Reset mid-debounce discards progress; an input held high across reset produces a rising edge N+1 cycles after release.

## Timing
- Edge 0 = first clock edge sampling the new in_port value.
- sync2 valid after edge 1; stable and EDGECAP update at edge 1+N; irq high in the cycle after edge 1+N (if masked in); DATA readable at readdata after edge 2+N.
- Pulses (post-synchronizer) shorter than N cycles: no stable change, no capture.
- PERIOD=0 and PERIOD=1 behave identically (N=1, total latency 2 cycles).
- No wait states; no back-pressure.

## Structure
- Package final385_soc_switch_pkg: address constants ADDR_DATA=0, ADDR_PERIOD=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3; DB_RESET default.
- Sub-module final385_soc_switch_debounce: one bit (synchronizer, counter, stable, rise pulse output), instantiated WIDTH times via generate; top holds register file, edge capture, irq, read mux.

## Test plan
- Reset release, read all four addresses → 0, DB_RESET (50000), 0, 0; irq=0.
- PERIOD=4; in_port 0000→0001 held → stable/EDGECAP[0] set at edge 5, DATA read returns 0x1, EDGECAP 0x1; irq stays 0 with IRQMASK=0.
- PERIOD=4, IRQMASK=0x1; 3-cycle pulse on in_port[0] → no change, irq 0; then 6-cycle pulse → EDGECAP=0x1, irq=1; write 0x1 to EDGECAP → irq=0 next cycle.
- IRQMASK=0xF; rising edge on bit 2 coincident with write 0x4 to EDGECAP → EDGECAP bit 2 remains 1, irq stays 1.
- in_port 0001→0000 after debounce → DATA=0 after N+2 cycles, EDGECAP unchanged.
- Assert reset_n mid-debounce (cnt=2, PERIOD=4) → all outputs 0 immediately and asynchronously; after release, held-high bit 1 captured at edge 5.

Source files
------------

// File: rtl/final385_soc_switch_pkg.sv
// Shared constants for the final385_soc switch/button controller.
//   ADDR_*           : Avalon-MM word addresses of the register map
//   DB_RESET_DEFAULT : power-on debounce period (1 ms at 50 MHz)
package final385_soc_switch_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_PERIOD  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int DB_RESET_DEFAULT = 50000;

endpackage

// File: rtl/final385_soc_switch_debounce.sv
// One-bit synchronizer plus debouncer.
//   clk, reset_n : system clock, async active-low reset
//   in_bit       : raw asynchronous pin
//   limit        : terminal count (N-1) for the debounce counter
//   stable       : debounced level
//   rise         : high in the cycle whose closing edge moves stable 0->1
module final385_soc_switch_debounce #(
  parameter int DB_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_bit,
  input  logic [DB_W-1:0] limit,
  output logic            stable,
  output logic            rise
);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;
  logic            done;

  // >= rather than == so a counter already past a newly shortened period
  // completes on the next mismatched cycle instead of wrapping.
  assign done = (sync2 != stable) && (cnt >= limit);
  assign rise = done && sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (done) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/final385_soc_switch_ctrl.sv
// Avalon-MM slave for board switches/buttons: debounced state, rising-edge
// capture with write-1-to-clear, and a maskable level interrupt.
//   clk, reset_n         : system clock, async active-low reset
//   address, chipselect,
//   write_n, writedata   : Avalon-MM slave write side
//   readdata             : registered read data, latency 1
//   in_port              : raw asynchronous pins
//   irq                  : level interrupt, |(EDGECAP & IRQMASK)
module final385_soc_switch_ctrl
  import final385_soc_switch_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DB_W     = 16,
  parameter int DB_RESET = DB_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [DB_W-1:0]  period;
  logic [DB_W-1:0]  limit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect && !write_n;
  assign unused_wdata = ^writedata[31:DB_W];

  // PERIOD of 0 behaves as 1.
  assign limit = (period == '0) ? '0 : period - 1'b1;

  assign clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    final385_soc_switch_debounce #(.DB_W(DB_W)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[i]),
      .limit   (limit),
      .stable  (stable[i]),
      .rise    (rise[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period   <= DB_W'(DB_RESET);
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
    end else begin
      if (wr && address == ADDR_PERIOD)  period  <= writedata[DB_W-1:0];
      if (wr && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      // A capture on the same edge as its clear survives.
      edgecap <= (edgecap & ~clr) | rise;
      unique case (address)
        ADDR_DATA:    readdata <= {{(32-WIDTH){1'b0}}, stable};
        ADDR_PERIOD:  readdata <= {{(32-DB_W){1'b0}}, period};
        ADDR_IRQMASK: readdata <= {{(32-WIDTH){1'b0}}, irqmask};
        ADDR_EDGECAP: readdata <= {{(32-WIDTH){1'b0}}, edgecap};
      endcase
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule
